// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and round-robin helpers for the intersection arbiter
package traffic_pkg;

  typedef enum logic [1:0] {
    red    = 2'b00,
    yellow = 2'b01,
    green  = 2'b10
  } color_t;

  typedef enum logic [1:0] {
    PH_EW_LEFT = 2'd0,
    PH_EW_STR  = 2'd1,
    PH_NS_LEFT = 2'd2,
    PH_NS_STR  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW
  } arb_state_t;

  // Slot k of the rotation is RR_ORDER[2k +: 2]: ew_str, ew_left, ns_str, ns_left.
  localparam logic [7:0] RR_ORDER = {PH_NS_LEFT, PH_NS_STR, PH_EW_LEFT, PH_EW_STR};

  function automatic phase_t rr_next(input phase_t p);
    rr_next = PH_EW_STR;
    for (int k = 0; k < 4; k++) begin
      if (RR_ORDER[2*k +: 2] == p) rr_next = phase_t'(RR_ORDER[2*((k+1)%4) +: 2]);
    end
  endfunction

  function automatic logic [7:0] light_vec(input phase_t p, input color_t c);
    light_vec = '0;
    case (p)
      PH_EW_LEFT: light_vec[1:0] = c;
      PH_EW_STR:  light_vec[3:2] = c;
      PH_NS_LEFT: light_vec[5:4] = c;
      default:    light_vec[7:6] = c;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_rr_phase_picker.sv
// rtl/traffic_phase_arbiter_rr_phase_picker.sv - rotating-priority encoder over the four phases
module rr_phase_picker
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] rr_last,
  output logic [1:0] grant_phase,
  output logic       grant_valid
);

  phase_t cand;

  always_comb begin
    grant_phase = PH_EW_LEFT;
    grant_valid = 1'b0;
    cand        = phase_t'(rr_last);
    for (int i = 0; i < 4; i++) begin
      cand = rr_next(cand);
      if (req[cand] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_phase = cand;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// rtl/traffic_phase_arbiter.sv - four-phase intersection scheduler with min/max green and preemption
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 10,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       preempt,
  input  logic [1:0] preempt_phase,
  output logic [1:0] ew_left_light,
  output logic [1:0] ew_str_light,
  output logic [1:0] ns_left_light,
  output logic [1:0] ns_str_light,
  output logic [1:0] active_phase,
  output logic       phase_valid
);

  localparam int CW = $clog2(GREEN_MAX + 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  phase_t        cur;
  phase_t        rr_last;
  logic          rr_fresh;
  logic [7:0]    lights;
  logic [1:0]    rr_base;
  logic [1:0]    pick_phase;
  logic          pick_valid;
  phase_t        grant_sel;
  logic [3:0]    others;
  logic          own_req;

  // Until the first grant the search acts as if ns_left went last, so ew_str is tried first.
  assign rr_base   = rr_fresh ? PH_NS_LEFT : rr_last;
  assign grant_sel = preempt ? phase_t'(preempt_phase) : phase_t'(pick_phase);
  assign others    = req & ~(4'b0001 << cur);
  assign own_req   = req[cur];

  rr_phase_picker u_picker (
    .req         (req),
    .rr_last     (rr_base),
    .grant_phase (pick_phase),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ALL_RED;
      cnt          <= '0;
      cur          <= PH_EW_LEFT;
      rr_last      <= PH_EW_LEFT;
      rr_fresh     <= 1'b1;
      lights       <= '0;
      active_phase <= 2'd0;
      phase_valid  <= 1'b0;
    end else begin
      case (state)
        ALL_RED: begin
          if (int'(cnt) + 1 >= ALLRED_CYC) begin
            if (preempt || pick_valid) begin
              state        <= GREEN;
              cnt          <= CW'(1);
              cur          <= grant_sel;
              rr_last      <= grant_sel;
              rr_fresh     <= 1'b0;
              lights       <= light_vec(grant_sel, green);
              active_phase <= grant_sel;
              phase_valid  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GREEN: begin
          if ((preempt && preempt_phase != cur) ||
              (!preempt && int'(cnt) >= GREEN_MIN && others != 4'b0000 &&
               (!own_req || int'(cnt) >= GREEN_MAX))) begin
            state  <= YELLOW;
            cnt    <= CW'(1);
            lights <= light_vec(cur, yellow);
          end else if (preempt) begin
            // Held by preemption: park the timer so release resumes just past minimum green.
            cnt <= CW'(GREEN_MIN);
          end else if (int'(cnt) < GREEN_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        YELLOW: begin
          if (int'(cnt) >= YELLOW_CYC) begin
            state        <= ALL_RED;
            cnt          <= '0;
            lights       <= '0;
            active_phase <= 2'd0;
            phase_valid  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state        <= ALL_RED;
          cnt          <= '0;
          lights       <= '0;
          active_phase <= 2'd0;
          phase_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign ew_left_light = lights[1:0];
  assign ew_str_light  = lights[3:2];
  assign ns_left_light = lights[5:4];
  assign ns_str_light  = lights[7:6];

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb/tb_traffic_phase_arbiter.sv - directed self-checking bench for traffic_phase_arbiter
module tb_traffic_phase_arbiter;

  localparam int R = 0;
  localparam int Y = 1;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       preempt = 1'b0;
  logic [1:0] preempt_phase = 2'd0;
  logic [1:0] ew_left_light, ew_str_light, ns_left_light, ns_str_light;
  logic [1:0] active_phase;
  logic       phase_valid;

  int checks = 0;
  int failures = 0;
  int order[4] = '{1, 0, 3, 2};

  traffic_phase_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .ew_left_light (ew_left_light),
    .ew_str_light  (ew_str_light),
    .ns_left_light (ns_left_light),
    .ns_str_light  (ns_str_light),
    .active_phase  (active_phase),
    .phase_valid   (phase_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // col R means every light red and no active phase.
  task automatic chk_now(input string tag, input int col, input int ph);
    logic [7:0] exp_l;
    exp_l = (col == R) ? 8'h00 : 8'(col << (2 * ph));
    chk({tag, ".lights"}, int'({ns_str_light, ns_left_light, ew_str_light, ew_left_light}), int'(exp_l));
    chk({tag, ".valid"}, int'(phase_valid), (col == R) ? 0 : 1);
    chk({tag, ".phase"}, int'(active_phase), (col == R) ? 0 : ph);
  endtask

  task automatic expect_cycles(input string tag, input int n, input int col, input int ph);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_now(tag, col, ph);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_now("post_reset", R, 0);
  endtask

  initial begin
    // Reset state and idle
    tick();
    tick();
    chk_now("reset_state", R, 0);
    reset = 1'b0;
    expect_cycles("idle", 50, R, 0);

    // Single request, rest in green, then hand-off to ns_str
    do_reset();
    req = 4'b0001;
    expect_cycles("t2_green", 2, G, 0);
    req = 4'b0000;
    expect_cycles("t2_rest", 6, G, 0);
    req = 4'b1000;
    expect_cycles("t2_yellow", 2, Y, 0);
    expect_cycles("t2_clear", 1, R, 0);
    expect_cycles("t2_ns_str", 1, G, 3);

    // All requesting: round-robin with max green
    do_reset();
    req = 4'b1111;
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 4; k++) begin
        expect_cycles("t3_green", 10, G, order[k]);
        expect_cycles("t3_yellow", 2, Y, order[k]);
        expect_cycles("t3_clear", 1, R, 0);
      end
    end

    // Own request drops: green ends at minimum
    do_reset();
    req = 4'b1000;
    expect_cycles("t4_g1", 1, G, 3);
    req = 4'b1010;
    expect_cycles("t4_g2", 1, G, 3);
    req = 4'b0010;
    expect_cycles("t4_g3to5", 3, G, 3);
    expect_cycles("t4_yellow", 2, Y, 3);
    expect_cycles("t4_clear", 1, R, 0);
    expect_cycles("t4_ew_str", 1, G, 1);

    // Preemption to ns_left during ew_str green, then release
    do_reset();
    req = 4'b1111;
    expect_cycles("t5_green", 2, G, 1);
    preempt = 1'b1;
    preempt_phase = 2'd2;
    expect_cycles("t5_yellow", 2, Y, 1);
    expect_cycles("t5_clear", 1, R, 0);
    expect_cycles("t5_held", 30, G, 2);
    preempt = 1'b0;
    expect_cycles("t5_release", 5, G, 2);
    expect_cycles("t5_yel_after", 1, Y, 2);

    // Reset in the middle of ew_left yellow
    do_reset();
    req = 4'b1111;
    expect_cycles("t6_ew_str", 10, G, 1);
    expect_cycles("t6_y1", 2, Y, 1);
    expect_cycles("t6_c1", 1, R, 0);
    expect_cycles("t6_ew_left", 10, G, 0);
    expect_cycles("t6_y2", 1, Y, 0);
    do_reset();
    expect_cycles("t6_restart", 1, G, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
